req_vec_ctrl: RTL and testbench



---
 rtl/req_vec_ctrl.sv | 145 ++++++++++++++
 tb/tb_req_vec_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/req_vec_ctrl.sv
// Request-vector grant controller: one-hot grant with ack handshake, hold pause and timeout.
// Define REQ_VEC_CTRL_RR_EN for round-robin selection; fixed lowest-index priority otherwise.
module req_vec_ctrl #(
   parameter int N    = 7,
   parameter int TMAX = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         hold,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [N-1:0] grant,
   output logic         grant_vld,
   output logic         idle,
   output logic         timeout
);

   // state    | meaning
   // ST_IDLE  | no grant held, waiting for en & |req
   // ST_GRANT | one-hot grant held, wait counter running unless hold
   // ST_COOL  | single dead cycle after ack or timeout, grant cleared

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_COOL  = 2'd2;

   localparam int             CW       = $clog2(TMAX + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TMAX - 1);

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  sel_vec;
   logic          tmo;

`ifdef REQ_VEC_CTRL_RR_EN
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] ptr_nxt;
   logic          found;
   int            k;

   // Rotating search from ptr_q; the first hit also yields the next pointer.
   always_comb begin
      sel_vec = '0;
      ptr_nxt = ptr_q;
      found   = 1'b0;
      k       = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr_q) + i;
         if (k >= N) k = k - N;
         if (!found && req[k]) begin
            found      = 1'b1;
            sel_vec[k] = 1'b1;
            ptr_nxt    = (k == N - 1) ? '0 : PW'(k + 1);
         end
      end
   end
`else
   // Isolate the lowest set bit.
   always_comb begin
      sel_vec = req & (~req + N'(1));
   end
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      tmo     = 1'b0;
`ifdef REQ_VEC_CTRL_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (en && (|req)) begin
               state_d = ST_GRANT;
               grant_d = sel_vec;
               cnt_d   = '0;
`ifdef REQ_VEC_CTRL_RR_EN
               ptr_d   = ptr_nxt;
`endif
            end
         end
         ST_GRANT: begin
            if (!en) begin
               state_d = ST_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (!hold) begin
               // ack takes precedence over an expiry in the same cycle
               if (ack) begin
                  state_d = ST_COOL;
                  grant_d = '0;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_COOL;
                  grant_d = '0;
                  cnt_d   = '0;
                  tmo     = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_COOL: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
`ifdef REQ_VEC_CTRL_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
`ifdef REQ_VEC_CTRL_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign grant_vld = (state_q == ST_GRANT) && !hold;
   assign idle      = ~(|req);
   // Pulse is visible during the expiring GRANT cycle itself.
   assign timeout   = tmo && !rst;

endmodule

// File: tb/tb_req_vec_ctrl.sv
// Directed bench for req_vec_ctrl (N=7, TMAX=3); follows REQ_VEC_CTRL_RR_EN if defined.
module tb_req_vec_ctrl;

   localparam int N    = 7;
   localparam int TMAX = 3;
`ifdef REQ_VEC_CTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         en;
   logic         hold;
   logic [N-1:0] req;
   logic         ack;
   logic [N-1:0] grant;
   logic         grant_vld;
   logic         idle;
   logic         timeout;

   int n_chk;
   int n_err;

   req_vec_ctrl #(.N(N), .TMAX(TMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .hold      (hold),
      .req       (req),
      .ack       (ack),
      .grant     (grant),
      .grant_vld (grant_vld),
      .idle      (idle),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [N-1:0] g, input logic v, input logic t);
      check({tag, "_grant"}, 32'(grant), 32'(g));
      check({tag, "_vld"}, 32'(grant_vld), 32'(v));
      check({tag, "_tmo"}, 32'(timeout), 32'(t));
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst  = 1'b1;
      en   = 1'b0;
      hold = 1'b0;
      req  = '0;
      ack  = 1'b0;
      tick();
      tick();
      check_out("reset", 7'b0, 1'b0, 1'b0);
      check("reset_idle", 32'(idle), 32'd1);

      // first grant right after reset release, fixed lowest index
      rst = 1'b0;
      en  = 1'b1;
      req = 7'b0010100;
      #1;
      check("idle_low", 32'(idle), 32'd0);
      tick();
      check_out("first_grant", 7'b0000100, 1'b1, 1'b0);

      ack = 1'b1;
      #1;
      check("ack_no_tmo", 32'(timeout), 32'd0);
      tick();
      ack = 1'b0;
      check_out("cool", 7'b0, 1'b0, 1'b0);
      tick();
      check_out("back_idle", 7'b0, 1'b0, 1'b0);
      tick();
      check_out("repeat_grant", RR ? 7'b0010000 : 7'b0000100, 1'b1, 1'b0);

      // timeout: no ack, expires in the 3rd GRANT cycle
      tick();
      check_out("tmo_c2", RR ? 7'b0010000 : 7'b0000100, 1'b1, 1'b0);
      tick();
      check_out("tmo_c3", RR ? 7'b0010000 : 7'b0000100, 1'b1, 1'b1);
      tick();
      check_out("tmo_cool", 7'b0, 1'b0, 1'b0);
      tick();
      check_out("tmo_idle", 7'b0, 1'b0, 1'b0);
      tick();
      check_out("tmo_regrant", 7'b0000100, 1'b1, 1'b0);

      // hold for 5 cycles, ack under hold ignored
      hold = 1'b1;
      #1;
      check_out("hold_0", 7'b0000100, 1'b0, 1'b0);
      tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("hold_ack_ign", 7'b0000100, 1'b0, 1'b0);
      tick();
      tick();
      check_out("hold_5", 7'b0000100, 1'b0, 1'b0);
      hold = 1'b0;
      #1;
      check_out("hold_rel", 7'b0000100, 1'b1, 1'b0);
      tick();
      check_out("hold_c2", 7'b0000100, 1'b1, 1'b0);
      tick();
      check_out("hold_c3", 7'b0000100, 1'b1, 1'b1);

      // ack coincident with expiry
      ack = 1'b1;
      #1;
      check("ack_vs_tmo", 32'(timeout), 32'd0);
      tick();
      ack = 1'b0;
      check_out("ack_vs_tmo_cool", 7'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_out("en_grant", RR ? 7'b0010000 : 7'b0000100, 1'b1, 1'b0);

      // en low inside GRANT, then en low in IDLE
      en = 1'b0;
      #1;
      check("en_low_tmo", 32'(timeout), 32'd0);
      tick();
      check_out("en_low_idle", 7'b0, 1'b0, 1'b0);
      tick();
      check_out("en_low_stay", 7'b0, 1'b0, 1'b0);
      en = 1'b1;
      tick();
      check_out("en_back", 7'b0000100, 1'b1, 1'b0);

      // request withdrawn, grant held
      req = '0;
      #1;
      check("idle_again", 32'(idle), 32'd1);
      tick();
      check_out("withdrawn", 7'b0000100, 1'b1, 1'b0);

      // reset mid-GRANT with simultaneous ack
      rst = 1'b1;
      ack = 1'b1;
      tick();
      check_out("rst_grant", 7'b0, 1'b0, 1'b0);
      rst = 1'b0;
      ack = 1'b0;
      req = 7'b1000001;
      tick();
      check_out("rr_g0", 7'b0000001, 1'b1, 1'b0);

      // acked grants with both ends of the vector requesting
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      check_out("rr_g1", RR ? 7'b1000000 : 7'b0000001, 1'b1, 1'b0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      check_out("rr_g2", 7'b0000001, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
